// File: rtl/fetch_inst_buffer.sv
// rtl/fetch_inst_buffer.sv - beat FIFO between Sysbus fetch responses and decode, 32-bit instruction split.
// Optional FETCH_TRACE_EN: prints each transfer and the halt PC, and checks response tags.
module fetch_inst_buffer #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int DEPTH          = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      line_start,
    input  logic [63:0]               line_addr,
    output logic                      can_accept,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [31:0]               inst,
    output logic [63:0]               inst_pc,
    input  logic                      flush,
    output logic                      halt,
    output logic                      proto_err
);
    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem_data [DEPTH];
    logic [63:0]   mem_pc   [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [3:0]    beats_remaining;
    logic [2:0]    beat_idx;
    logic [63:0]   line_base;
    logic          half, drop, halt_q, proto_q;

    logic          empty, free_ok, beat_ack, wr_en, fire, pop, head_zero, tag_err;
    logic [63:0]   head_data, head_pc, beat_pc;

`ifdef FETCH_TRACE_EN
    localparam logic [BUS_TAG_WIDTH-1:0] SYSBUS_READ   = BUS_TAG_WIDTH'(1);
    localparam logic [BUS_TAG_WIDTH-1:0] SYSBUS_MEMORY = BUS_TAG_WIDTH'(1);
    localparam logic [BUS_TAG_WIDTH-1:0] TAG_EXPECTED  = (SYSBUS_READ << 12) | (SYSBUS_MEMORY << 8);
    assign tag_err = bus_respcyc && (bus_resptag != TAG_EXPECTED);
`else
    logic unused_tag;
    assign unused_tag = ^bus_resptag;
    assign tag_err    = 1'b0;
`endif

    always_comb begin
        empty      = (count == '0);
        free_ok    = ((AW+1)'(DEPTH) - count) >= (AW+1)'(8);
        can_accept = !reset && (beats_remaining == 4'd0) && free_ok && !halt_q && !flush;
        beat_ack   = !reset && bus_respcyc && (beats_remaining != 4'd0);
        wr_en      = beat_ack && !drop && !flush;
        beat_pc    = line_base + {58'd0, beat_idx, 3'd0};
        head_data  = mem_data[rd_ptr];
        head_pc    = mem_pc[rd_ptr];
        inst       = half ? head_data[63:32] : head_data[31:0];
        inst_pc    = head_pc + {61'd0, half, 2'd0};
        head_zero  = !empty && (inst == 32'd0);
        inst_valid = !reset && !empty && !halt_q && (inst != 32'd0) && !flush;
        fire       = inst_valid && inst_ready;
        pop        = fire && half;
        bus_respack = beat_ack;
        halt       = halt_q && !reset;
        proto_err  = proto_q && !reset;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= bus_resp[63:0];
            mem_pc[wr_ptr]   <= beat_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            beats_remaining <= 4'd0;
            beat_idx        <= 3'd0;
            line_base       <= 64'd0;
            half            <= 1'b0;
            drop            <= 1'b0;
            halt_q          <= 1'b0;
            proto_q         <= 1'b0;
        end else begin
            if ((line_start && !can_accept) || (bus_respcyc && beats_remaining == 4'd0) || tag_err)
                proto_q <= 1'b1;

            if (line_start && can_accept) begin
                line_base       <= line_addr;
                beat_idx        <= 3'd0;
                beats_remaining <= 4'd8;
            end else if (beat_ack) begin
                beat_idx        <= beat_idx + 3'd1;
                beats_remaining <= beats_remaining - 4'd1;
            end

            // Drop mode lasts until the interrupted line's last beat has been acked.
            if (beat_ack && beats_remaining == 4'd1)
                drop <= 1'b0;
            else if (flush && beats_remaining != 4'd0)
                drop <= 1'b1;

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                half   <= 1'b0;
                halt_q <= 1'b0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
                if (fire)
                    half <= ~half;
                if (head_zero)
                    halt_q <= 1'b1;
            end
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && fire)
            $display("%x\t%h", inst_pc, inst);
        if (!reset && !flush && head_zero && !halt_q)
            $display("fetch halt at %x", inst_pc);
    end
`endif
endmodule

// File: tb/tb_fetch_inst_buffer.sv
// tb/tb_fetch_inst_buffer.sv - scoreboard testbench for fetch_inst_buffer.
module tb_fetch_inst_buffer;
    logic        clk = 1'b0;
    logic        reset, line_start, can_accept, bus_respcyc, bus_respack;
    logic        inst_valid, inst_ready, flush, halt, proto_err;
    logic [63:0] line_addr, bus_resp, inst_pc;
    logic [12:0] bus_resptag;
    logic [31:0] inst;

    int          vectors = 0;
    int          miscompares = 0;
    logic [95:0] exp_q [$];
    logic [95:0] exp_e;
    bit          exp_halted = 0;
    logic [63:0] line_data [8];

    always #5 clk = ~clk;

    fetch_inst_buffer dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_addr(line_addr),
        .can_accept(can_accept), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respack(bus_respack), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .flush(flush),
        .halt(halt), .proto_err(proto_err)
    );

    always @(negedge clk) begin
        if (!reset && inst_valid && inst_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_inst pc=%h inst=%h required no transfer", inst_pc, inst);
            end else begin
                exp_e = exp_q.pop_front();
                if ({inst_pc, inst} !== exp_e) begin
                    miscompares++;
                    $display("FAIL inst_order got pc=%h inst=%h required pc=%h inst=%h",
                             inst_pc, inst, exp_e[95:32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_line(input logic [63:0] addr);
        int n = 0;
        while (!can_accept && n < 100) begin
            step();
            n++;
        end
        vectors++;
        if (can_accept !== 1'b1) begin
            miscompares++;
            $display("FAIL start_wait can_accept=%b required 1", can_accept);
        end
        line_start = 1'b1;
        line_addr  = addr;
        step();
        line_start = 1'b0;
    endtask

    task automatic send_beats(input logic [63:0] base, input int first, input int last, input bit push);
        for (int i = first; i <= last; i++) begin
            bus_respcyc = 1'b1;
            bus_resp    = line_data[i];
            if (push && !exp_halted) begin
                if (line_data[i][31:0] == 32'd0) exp_halted = 1;
                else begin
                    exp_q.push_back({base + 64'(i * 8), line_data[i][31:0]});
                    if (line_data[i][63:32] == 32'd0) exp_halted = 1;
                    else exp_q.push_back({base + 64'(i * 8 + 4), line_data[i][63:32]});
                end
            end
            @(negedge clk);
            vectors++;
            if (bus_respack !== 1'b1) begin
                miscompares++;
                $display("FAIL beat_ack beat=%0d got=%b required 1", i, bus_respack);
            end
            step();
        end
        bus_respcyc = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain remaining=%0d required 0", name, exp_q.size());
        end
        repeat (3) step();
    endtask

    task automatic fill_data(input logic [31:0] seed);
        for (int i = 0; i < 8; i++)
            line_data[i] = {seed + 32'(2 * i + 1), seed + 32'(2 * i)};
    endtask

    task automatic test_reset();
        reset = 1'b1; line_start = 1'b1; line_addr = 64'd0; bus_respcyc = 1'b1;
        bus_resp = 64'd1; bus_resptag = 13'h1100; inst_ready = 1'b0; flush = 1'b0;
        repeat (2) step();
        @(negedge clk);
        vectors += 5;
        if (can_accept !== 1'b0) begin miscompares++; $display("FAIL rst_can_accept got=%b required 0", can_accept); end
        if (bus_respack !== 1'b0) begin miscompares++; $display("FAIL rst_respack got=%b required 0", bus_respack); end
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_inst_valid got=%b required 0", inst_valid); end
        if (halt !== 1'b0) begin miscompares++; $display("FAIL rst_halt got=%b required 0", halt); end
        if (proto_err !== 1'b0) begin miscompares++; $display("FAIL rst_proto_err got=%b required 0", proto_err); end
        step();
        reset = 1'b0; line_start = 1'b0; bus_respcyc = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (can_accept !== 1'b1) begin miscompares++; $display("FAIL post_rst_can_accept got=%b required 1", can_accept); end
        if (proto_err !== 1'b0) begin miscompares++; $display("FAIL post_rst_proto_err got=%b required 0", proto_err); end
    endtask

    task automatic test_single_line();
        inst_ready = 1'b1;
        fill_data(32'hA000_0000);
        start_line(64'h1000);
        send_beats(64'h1000, 0, 7, 1);
        wait_drain("single_line");
        vectors++;
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL single_idle inst_valid=%b required 0", inst_valid); end
    endtask

    task automatic test_back_to_back();
        inst_ready = 1'b0;
        fill_data(32'hB000_0000);
        start_line(64'h3000);
        send_beats(64'h3000, 0, 7, 1);
        fill_data(32'hC000_0000);
        start_line(64'h3040);
        send_beats(64'h3040, 0, 7, 1);
        @(negedge clk);
        vectors += 2;
        if (can_accept !== 1'b0) begin miscompares++; $display("FAIL full_can_accept got=%b required 0", can_accept); end
        if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL full_inst_valid got=%b required 1", inst_valid); end
        step();
        inst_ready = 1'b1;
        wait_drain("back_to_back");
    endtask

    task automatic test_zero_word();
        inst_ready = 1'b1;
        exp_halted = 0;
        fill_data(32'hD000_0000);
        line_data[3] = 64'h0000_0000_0000_0013;
        start_line(64'h2000);
        send_beats(64'h2000, 0, 7, 1);
        wait_drain("zero_word");
        repeat (5) step();
        vectors += 3;
        if (halt !== 1'b1) begin miscompares++; $display("FAIL zero_halt got=%b required 1", halt); end
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL zero_inst_valid got=%b required 0", inst_valid); end
        if (can_accept !== 1'b0) begin miscompares++; $display("FAIL zero_can_accept got=%b required 0", can_accept); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_halted = 0;
        @(negedge clk);
        vectors += 2;
        if (halt !== 1'b0) begin miscompares++; $display("FAIL unhalt got=%b required 0", halt); end
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL unhalt_valid got=%b required 0", inst_valid); end
        step();
    endtask

    task automatic test_flush_midline();
        inst_ready = 1'b0;
        fill_data(32'hE000_0000);
        start_line(64'h4000);
        send_beats(64'h4000, 0, 2, 0);
        flush = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL flush_cycle_valid got=%b required 0", inst_valid); end
        step();
        flush = 1'b0;
        vectors += 2;
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL flush_empty_valid got=%b required 0", inst_valid); end
        if (can_accept !== 1'b0) begin miscompares++; $display("FAIL flush_can_accept got=%b required 0", can_accept); end
        send_beats(64'h4000, 3, 6, 0);
        vectors++;
        if (can_accept !== 1'b0) begin miscompares++; $display("FAIL drop7_can_accept got=%b required 0", can_accept); end
        send_beats(64'h4000, 7, 7, 0);
        vectors++;
        if (can_accept !== 1'b1) begin miscompares++; $display("FAIL drop8_can_accept got=%b required 1", can_accept); end
        repeat (3) step();
        vectors++;
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL drop_discard_valid got=%b required 0", inst_valid); end
    endtask

    task automatic test_line_start_overlap();
        inst_ready = 1'b1;
        vectors++;
        if (proto_err !== 1'b0) begin miscompares++; $display("FAIL pre_overlap_proto got=%b required 0", proto_err); end
        fill_data(32'hF000_0000);
        start_line(64'h5000);
        send_beats(64'h5000, 0, 3, 1);
        line_start = 1'b1;
        line_addr  = 64'h6000;
        @(negedge clk);
        vectors++;
        if (can_accept !== 1'b0) begin miscompares++; $display("FAIL overlap_can_accept got=%b required 0", can_accept); end
        step();
        line_start = 1'b0;
        vectors++;
        if (proto_err !== 1'b1) begin miscompares++; $display("FAIL overlap_proto got=%b required 1", proto_err); end
        send_beats(64'h5000, 4, 7, 1);
        wait_drain("overlap");
        vectors++;
        if (can_accept !== 1'b1) begin miscompares++; $display("FAIL overlap_done_can_accept got=%b required 1", can_accept); end
    endtask

    task automatic test_reset_midline();
        inst_ready = 1'b0;
        fill_data(32'h1234_0000);
        start_line(64'h7000);
        send_beats(64'h7000, 0, 1, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        inst_ready = 1'b1;
        vectors += 2;
        if (proto_err !== 1'b0) begin miscompares++; $display("FAIL rst_mid_proto got=%b required 0", proto_err); end
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got=%b required 0", inst_valid); end
        bus_respcyc = 1'b1;
        bus_resp    = 64'h55;
        @(negedge clk);
        vectors++;
        if (bus_respack !== 1'b0) begin miscompares++; $display("FAIL stray_ack got=%b required 0", bus_respack); end
        step();
        bus_respcyc = 1'b0;
        vectors++;
        if (proto_err !== 1'b1) begin miscompares++; $display("FAIL stray_proto got=%b required 1", proto_err); end
    endtask

`ifdef FETCH_TRACE_EN
    task automatic test_trace_tag();
        reset = 1'b1;
        step();
        reset = 1'b0;
        inst_ready = 1'b1;
        exp_halted = 0;
        fill_data(32'h7700_0000);
        start_line(64'h8000);
        bus_resptag = 13'h0000;
        send_beats(64'h8000, 0, 0, 1);
        bus_resptag = 13'h1100;
        vectors++;
        if (proto_err !== 1'b1) begin miscompares++; $display("FAIL tag_proto got=%b required 1", proto_err); end
        send_beats(64'h8000, 1, 7, 1);
        wait_drain("trace");
    endtask
`endif

    initial begin
        test_reset();
        test_single_line();
        test_back_to_back();
        test_zero_word();
        test_flush_midline();
        test_line_start_overlap();
        test_reset_midline();
`ifdef FETCH_TRACE_EN
        test_trace_tag();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_inst_buffer.md
Name: fetch_inst_buffer

Overview:
- Sits directly downstream of the fetch line requester, between the Sysbus response channel and the decode stage.
- Captures the 8 response beats of each 64-byte instruction line into a beat FIFO and acknowledges them on the bus.
- Splits each 64-bit beat into two 32-bit instructions, tagged with their PCs, and hands them to decode over a valid/ready handshake.
- Detects the all-zero end-of-program word and halts the instruction stream.

Parameters:
- BUS_DATA_WIDTH, 64: Sysbus data width; must be 64.
- BUS_TAG_WIDTH, 13: Sysbus tag width.
- DEPTH, 16: beat FIFO entries; power of two, minimum 8.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- line_start  input  1  pulse: line request issued upstream this cycle
- line_addr  input  64  byte address of the requested line (64-byte aligned)
- can_accept  output  1  upstream may pulse line_start this cycle
- bus_respcyc  input  1  response beat valid
- bus_resp  input  BUS_DATA_WIDTH  response data
- bus_resptag  input  BUS_TAG_WIDTH  response tag; ignored except under the optional feature
- bus_respack  output  1  beat accepted
- inst_valid  output  1  instruction available to decode
- inst_ready  input  1  decode accepts instruction
- inst  output  32  instruction word
- inst_pc  output  64  instruction byte address
- flush  input  1  discard all buffered and in-flight instructions
- halt  output  1  sticky: zero instruction reached
- proto_err  output  1  sticky: illegal line_start

Behaviour:
- Reset (synchronous, active-high, clk): FIFO empty; beats_remaining=0; beat_idx=0; half=0; drop=0. halt, proto_err, inst_valid, bus_respack and can_accept are 0 during reset; can_accept becomes 1 the first cycle after reset.
- can_accept = (beats_remaining==0) && (free entries >= 8) && !halt && !flush.
- line_start:
  - Legal when can_accept=1: loads line_base=line_addr, beat_idx=0, beats_remaining=8.
  - When can_accept=0: ignored and sets proto_err. proto_err stays set until reset.
- Beat capture:
  - bus_respack = bus_respcyc && (beats_remaining!=0). This is combinational and same-cycle. The free-space check guarantees room.
  - An accepted beat writes {line_base + beat_idx*8, bus_resp}, then beat_idx+1 (3-bit) and beats_remaining-1.
  - bus_respcyc with beats_remaining==0: no ack; sets proto_err.
- Output:
  - Head entry plus half select: inst = half ? data[63:32] : data[31:0]; inst_pc = beat_pc + half*4.
  - inst_valid = FIFO non-empty && !halt && inst != 0.
  - Transfer on inst_valid && inst_ready: half toggles; on the half 1->0 toggle the head is popped.
- Latency: a beat accepted in cycle N gives its lower instruction on inst_valid in cycle N+1 (registered FIFO storage). A write and a pop in the same cycle are both allowed, including when the FIFO is full.
- Zero word: when the head word is 0x00000000, halt sets the next cycle. That word is never emitted. inst_valid stays 0 until flush or reset. A beat with a nonzero lower and zero upper half emits the lower word, then halts.
- Flush (synchronous, one cycle):
  - Empties the FIFO, clears half and halt.
  - If beats_remaining != 0, sets drop. In drop mode later beats are still acked but not written; drop clears when beats_remaining reaches 0.
  - inst_valid=0 in the flush cycle.
  - flush together with line_start: line_start is ignored (can_accept=0) and proto_err is set.
- Reset mid-line: all state clears. Stray later beats are not acked and set proto_err.

Optional Feature:
- Macro: FETCH_TRACE_EN.
- Defined:
  - Each instruction transfer prints $display("%x\t%h", inst_pc, inst).
  - Halt prints "fetch halt at %x" with the zero word's PC.
  - A beat whose bus_resptag differs from (SYSBUS_READ<<12 | SYSBUS_MEMORY<<8) sets proto_err.
- Undefined: no display statements and no tag check; ports are unchanged.

Test Plan:
- Reset, then line_start with line_addr=0x1000, 8 beats of nonzero data, inst_ready=1 -> 16 instructions in order, inst_pc 0x1000..0x103C step 4; bus_respack=1 on each beat cycle.
- inst_ready=0 while 16 beats arrive (DEPTH=16) -> can_accept=0 after the second line_start; releasing ready drains 32 instructions in order with no loss.
- Beat 3 of line 0x2000 = 0x00000000_00000013 -> instructions through 0x2018 (value 0x13) emitted; halt=1 next cycle; inst_valid stays 0; no instruction for PC 0x201C.
- flush after 3 of 8 beats -> FIFO empty, inst_valid=0; remaining 5 beats acked and discarded; can_accept=1 only after the 8th beat.
- line_start while beats_remaining=4 -> proto_err=1, line_base unchanged, current line completes normally.
- With FETCH_TRACE_EN, a beat tagged 0x0000 -> proto_err=1 and each transfer printed as "%x\t%h".
